imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the MIPS instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words, matching the hex word order used in instruction images.
- Writes each word to consecutive instruction-memory addresses starting at word 0.
- Holds the CPU in hold (PC forced to 0) until the programmed word count has been written, then releases it.

Parameters:
- ADDR_W, 8, instruction memory word-address width; depth = 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load session.
- len_words  in  ADDR_W+1  number of words to load; sampled when start is accepted.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  1 = CPU held (PC forced to 0, no register-file writes).
- busy  out  1  load session in progress.
- done  out  1  session finished successfully; held high until the next accepted start.
- err  out  1  length error on the last session; held high until the next accepted start.

Behaviour:
- Reset: rst_n is asynchronous and active-low. Clock is clk.
  - Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0.
  - Byte counter, word counter and latched length are all cleared.
- States:
  - IDLE: cpu_hold=1, in_ready=0.
    - start=1 latches len_words into len_q, clears done/err and the counters.
    - If len_words=0: go to DONE (zero-length load is legal).
    - If len_words > 2^ADDR_W: set err=1 and go to FAIL; no writes occur.
    - Otherwise: go to LOAD.
  - LOAD: busy=1, in_ready=1.
    - A byte transfers when in_valid && in_ready.
    - Shift register: word_q <= {word_q[23:0], in_data], so the first byte lands in bits 31:24.
    - byte_cnt counts 0..3. On the 4th transfer, go to WRITE. No transfer means hold.
  - WRITE: exactly one cycle; busy=1, in_ready=0, imem_we=1, imem_addr=word_cnt, imem_wdata=word_q.
    - Next cycle: word_cnt increments. If word_cnt+1 == len_q, go to DONE; else go to LOAD.
  - DONE: busy=0, done=1, cpu_hold=0, in_ready=0.
  - FAIL: busy=0, err=1, cpu_hold=1, in_ready=0.
  - DONE and FAIL both accept start and behave exactly as IDLE does on start.
- Timing:
  - Minimum 5 clocks per word (4 byte transfers plus 1 write cycle).
  - cpu_hold falls in the first cycle DONE is entered, i.e. one cycle after the final imem_we pulse.
  - imem_we never asserts outside WRITE.
- Boundary cases:
  - start is ignored while in LOAD or WRITE.
  - in_valid is ignored when in_ready=0; bytes presented then are not consumed.
  - len_words = 2^ADDR_W is legal and fills memory exactly; word_cnt reaches 2^ADDR_W-1 with no wrap-around write.
  - Reset mid-session aborts immediately. Words already written stay in memory, the state returns to IDLE and cpu_hold=1.
  - imem_addr and imem_wdata are registered outputs and hold their last values outside WRITE.

Test Plan:
1. Reset, then start with len_words=2 and bytes 20,08,00,05,01,09,50,20, in_valid always high -> writes 0x20080005 @0 and 0x01095020 @1. imem_we high on cycles 5 and 10 after LOAD entry. done=1 and cpu_hold=0 one cycle after the second write.
2. Same stream with in_valid toggling 1,0,1,0 -> identical writes; each byte accepted exactly once; no imem_we during stalls.
3. start with len_words=0 -> DONE next cycle, no imem_we, done=1, cpu_hold=0.
4. start with len_words=257, ADDR_W=8 -> err=1, cpu_hold=1, no writes. A following start with len_words=1 clears err and loads normally.
5. Assert rst_n=0 after 2 bytes of word 1 in a 3-word load -> word 0 remains written, outputs return to reset values immediately. A new start reloads from address 0.
6. Pulse start during LOAD -> ignored; len_q and word_cnt unchanged; session completes with the original length.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader that sits in front of the instruction memory. It
// takes a byte stream over a valid/ready handshake and packs the bytes into
// big-endian 32-bit words, so the first byte of each group of four becomes
// bits 31:24. Each word is written to the next instruction-memory address,
// starting at word 0. The CPU is held (PC forced to 0) until the requested
// number of words has been written.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        single-cycle pulse that begins a load session
//   len_words    number of words to load, sampled when start is accepted
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     loader accepts a byte this cycle
//   imem_we      instruction-memory write strobe, one cycle per word
//   imem_addr    word address of the write (registered, holds between writes)
//   imem_wdata   assembled word (registered, holds between writes)
//   cpu_hold     1 = CPU held in reset-like state
//   busy         load session in progress
//   done         last session completed; held until the next accepted start
//   err          last session had an illegal length; held until next start
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len_words,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_FAIL
  } state_t;

  // Largest legal length: exactly fills the memory.
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path through
    // the case statement leaves it unassigned (which would infer a latch).
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          len_d      = len_words;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          if (len_words == '0) begin
            state_d = S_DONE;
          end else if (len_words > MAX_LEN) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        // in_ready is high throughout LOAD, so in_valid alone marks a transfer.
        if (in_valid) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Capture the write address and data now so both are already
            // registered when the single WRITE cycle presents them.
            addr_d  = word_cnt_q[ADDR_W-1:0];
            wdata_d = word_d;
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        // word_cnt is one bit wider than the address, so a full-memory load
        // reaches len_q without wrapping back to address 0.
        if (word_cnt_d == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Status outputs decode directly from the state register.
  assign in_ready   = (state_q == S_LOAD);
  assign imem_we    = (state_q == S_WRITE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_FAIL);
  assign cpu_hold   = (state_q != S_DONE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. The stimulus side computes, from the
// byte stream and requested length alone, the list of (address, word) writes
// a correct loader must perform and queues them. An independent monitor pops
// that queue whenever imem_we is seen and compares address and data.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len_words = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len_words  (len_words),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  int         last_we_cyc = -1;
  int         we_gap = 0;
  logic [31:0] last_exp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && imem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", {31'd0, imem_we}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", {24'd0, imem_addr}, e.addr);
          check("we_data", imem_wdata, e.data);
          check("we_in_ready", {31'd0, in_ready}, 32'd0);
        end
        we_gap      = cyc - last_we_cyc;
        last_we_cyc = cyc;
      end
    end
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_we"},       {31'd0, imem_we},  32'd0);
    check({tag, "_addr"},     {24'd0, imem_addr}, 32'd0);
    check({tag, "_wdata"},    imem_wdata,         32'd0);
    check({tag, "_hold"},     {31'd0, cpu_hold}, 32'd1);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  task automatic do_start(input int len);
    @(negedge clk);
    start     = 1'b1;
    len_words = len[ADDR_W:0];
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Drive tx_q bytes. mode: 0 = valid always, 1 = valid toggles, 2 = random.
  // glitch: byte index before which a stray start (len 0) is pulsed.
  // stop_after: stop once this many bytes are consumed (-1 = all).
  task automatic send_stream(input int mode, input int glitch, input int stop_after);
    int idx = 0;
    int budget = tx_q.size() * 8 + 100;
    bit v = 1'b0;
    bit glitched = 1'b0;
    while (tx_q.size() != 0 && budget > 0 && (stop_after < 0 || idx < stop_after)) begin
      @(negedge clk);
      budget--;
      start = 1'b0;
      if (idx == glitch && !glitched) begin
        start     = 1'b1;
        len_words = '0;
        glitched  = 1'b1;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = !v;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = v ? tx_q[0] : 8'($urandom);
      if (v && in_ready) begin
        void'(tx_q.pop_front());
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    if (budget == 0) check("stream_timeout", tx_q.size(), 32'd0);
  endtask

  task automatic wait_end(input bit exp_done, input int nwords);
    int n = 0;
    while (!(done || err) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'd0, done || err}, 32'd1);
    check("done",     {31'd0, done},     {31'd0, exp_done});
    check("err",      {31'd0, err},      {31'd0, !exp_done});
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !exp_done});
    check("busy_end", {31'd0, busy},     32'd0);
    check("ready_end", {31'd0, in_ready}, 32'd0);
    check("all_writes_seen", exp_q.size(), 32'd0);
    if (nwords > 0) begin
      check("hold_release_lat", cyc - last_we_cyc, 32'd1);
      check("addr_hold",  {24'd0, imem_addr}, nwords - 1);
      check("wdata_hold", imem_wdata, last_exp_data);
    end
    exp_q.delete();
  endtask

  // Reference: a legal length n produces writes of bytes 4i..4i+3, first byte
  // most significant, at addresses 0..n-1; other lengths produce none.
  task automatic run_session(input int len, input int mode, input int glitch, input bit given);
    int n;
    wr_t w;
    n = (len >= 1 && len <= DEPTH) ? len : 0;
    if (!given) begin
      tx_q.delete();
      for (int i = 0; i < n * 4; i++) tx_q.push_back(8'($urandom));
    end
    for (int i = 0; i < n; i++) begin
      w.addr = i;
      w.data = {tx_q[4*i], tx_q[4*i+1], tx_q[4*i+2], tx_q[4*i+3]};
      exp_q.push_back(w);
      last_exp_data = w.data;
    end
    do_start(len);
    if (n > 0) begin
      check("load_busy",  {31'd0, busy},     32'd1);
      check("load_done0", {31'd0, done},     32'd0);
      check("load_err0",  {31'd0, err},      32'd0);
      check("load_hold",  {31'd0, cpu_hold}, 32'd1);
      send_stream(mode, glitch, -1);
    end
    wait_end(len <= DEPTH, n);
  endtask

  initial begin
    logic [7:0] prog [8];
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};

    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed two-word program, valid always high; words are 5 cycles apart.
    tx_q.delete();
    foreach (prog[i]) tx_q.push_back(prog[i]);
    run_session(2, 0, -1, 1'b1);
    check("word_gap", we_gap, 32'd5);

    // Same program with in_valid toggling.
    tx_q.delete();
    foreach (prog[i]) tx_q.push_back(prog[i]);
    run_session(2, 1, -1, 1'b1);

    // Zero-length load.
    run_session(0, 0, -1, 1'b0);

    // Oversized length, then a normal one-word load clears err.
    run_session(DEPTH + 1, 0, -1, 1'b0);
    repeat (3) @(negedge clk);
    check("fail_hold", {31'd0, err}, 32'd1);
    run_session(1, 2, -1, 1'b0);

    // Stray start during LOAD and during WRITE must be ignored.
    run_session(2, 0, 2, 1'b0);
    run_session(2, 0, 4, 1'b0);

    // Reset mid-session: after word 0 and two bytes of word 1.
    begin
      wr_t w;
      tx_q.delete();
      for (int i = 0; i < 12; i++) tx_q.push_back(8'($urandom));
      w.addr = 0;
      w.data = {tx_q[0], tx_q[1], tx_q[2], tx_q[3]};
      exp_q.push_back(w);
      do_start(3);
      send_stream(0, -1, 6);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      check("word0_written", exp_q.size(), 32'd0);
      #2 rst_n = 1'b0;
      #1 check_reset_outs("mid_reset");
      tx_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_session(3, 2, -1, 1'b0);
    end

    // Randomized sessions.
    for (int k = 0; k < 6; k++) run_session($urandom_range(1, 6), 2, -1, 1'b0);
    run_session($urandom_range(DEPTH + 1, 2 * DEPTH - 1), 0, -1, 1'b0);

    // Full-memory load.
    run_session(DEPTH, 0, -1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
